// File: rtl/mem_port_arbiter5.sv
// Round-robin arbiter granting one shared memory port to five requesters,
// with a per-grant watchdog that aborts a transaction the port never acknowledges.
//
// state  | meaning
// S_IDLE | no grant; arbitrate among req_i this cycle
// S_BUSY | grant held for owner_q until mem_ack_i or watchdog expiry
module mem_port_arbiter5 #(
    parameter int PRIO0_FIXED    = 0,
    parameter int TIMEOUT_CYCLES = 1023,
    parameter int CNT_W          = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] req_i,
    input  logic       mem_ack_i,
    output logic [4:0] gnt_o,
    output logic [2:0] sel_o,
    output logic       mem_req_o,
    output logic [4:0] ack_o,
    output logic       err_o,
    output logic [2:0] err_id_o,
    output logic       busy_o
);

    localparam logic             S_IDLE    = 1'b0;
    localparam logic             S_BUSY    = 1'b1;
    localparam logic [2:0]       SEL_IDLE  = 3'b101;
    localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic             FIX0      = (PRIO0_FIXED != 0);

    logic             state_q, state_d;
    logic [2:0]       rr_ptr_q, rr_ptr_d;
    logic [2:0]       owner_q, owner_d;
    logic [CNT_W-1:0] wdog_q, wdog_d;
    logic [4:0]       gnt_q, gnt_d;
    logic [2:0]       sel_q, sel_d;
    logic             mem_req_q, mem_req_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;
    logic [2:0]       err_id_q, err_id_d;

    logic             win_found;
    logic [2:0]       win_idx;
    logic [3:0]       scan_idx;
    logic [2:0]       next_ptr;

    // Scan from rr_ptr upward modulo 5; index 0 leaves the rotation when it has fixed priority.
    always_comb begin
        win_found = 1'b0;
        win_idx   = 3'd0;
        scan_idx  = 4'd0;
        if (FIX0 && req_i[0]) begin
            win_found = 1'b1;
            win_idx   = 3'd0;
        end else begin
            for (int k = 0; k < 5; k++) begin
                scan_idx = {1'b0, rr_ptr_q} + 4'(k);
                if (scan_idx >= 4'd5) scan_idx = scan_idx - 4'd5;
                if (!win_found && req_i[scan_idx[2:0]] && !(FIX0 && scan_idx == 4'd0)) begin
                    win_found = 1'b1;
                    win_idx   = scan_idx[2:0];
                end
            end
        end
    end

    assign next_ptr = (owner_q == 3'd4) ? 3'd0 : owner_q + 3'd1;

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        wdog_d   = wdog_q;
        err_d    = 1'b0;
        err_id_d = 3'd0;
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    state_d = S_BUSY;
                    owner_d = win_idx;
                    wdog_d  = '0;
                end
            end
            default: begin
                if (mem_ack_i) begin
                    state_d  = S_IDLE;
                    rr_ptr_d = next_ptr;
                end else if (wdog_q == WDOG_LAST) begin
                    state_d  = S_IDLE;
                    rr_ptr_d = next_ptr;
                    err_d    = 1'b1;
                    err_id_d = owner_q;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
        endcase
    end

    // Grant-side outputs are registered from the next state so they are glitch-free for the whole grant.
    always_comb begin
        gnt_d     = 5'd0;
        sel_d     = SEL_IDLE;
        mem_req_d = 1'b0;
        busy_d    = 1'b0;
        if (state_d == S_BUSY) begin
            gnt_d     = 5'd1 << owner_d;
            sel_d     = owner_d;
            mem_req_d = 1'b1;
            busy_d    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            rr_ptr_q  <= 3'd0;
            owner_q   <= 3'd0;
            wdog_q    <= '0;
            gnt_q     <= 5'd0;
            sel_q     <= SEL_IDLE;
            mem_req_q <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
            err_id_q  <= 3'd0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            owner_q   <= owner_d;
            wdog_q    <= wdog_d;
            gnt_q     <= gnt_d;
            sel_q     <= sel_d;
            mem_req_q <= mem_req_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
            err_id_q  <= err_id_d;
        end
    end

    assign gnt_o     = gnt_q;
    assign sel_o     = sel_q;
    assign mem_req_o = mem_req_q;
    assign busy_o    = busy_q;
    assign err_o     = err_q;
    assign err_id_o  = err_id_q;
    assign ack_o     = gnt_q & {5{mem_ack_i}};

endmodule

// File: tb/tb_mem_port_arbiter5.sv
// Scoreboard bench for mem_port_arbiter5: a round-robin instance and a fixed-priority-0
// instance share stimulus; expected winners come from a transaction-level model.
module tb_mem_port_arbiter5;

    localparam int TMO = 4;

    typedef struct {
        int w0;
        int w1;
    } rec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] req;
    logic       ack_in;
    logic [4:0] gnt[2];
    logic [4:0] ack[2];
    logic [2:0] sel[2];
    logic [2:0] err_id[2];
    logic       mreq[2];
    logic       err[2];
    logic       busy[2];

    rec_t       exp_q[$];
    int         rd_idx[2]   = '{0, 0};
    int         cur_w[2]    = '{0, 0};
    int         acks_seen[2] = '{0, 0};
    int         errs_seen[2] = '{0, 0};
    logic [4:0] prev_gnt[2] = '{5'd0, 5'd0};
    int         ptr_m[2]    = '{0, 0};
    int         exp_acks    = 0;
    int         exp_errs    = 0;
    int         errors      = 0;
    int         checks      = 0;

    always #5 clk = ~clk;

    mem_port_arbiter5 #(.PRIO0_FIXED(0), .TIMEOUT_CYCLES(TMO), .CNT_W(4)) dut_rr (
        .clk(clk), .rst(rst), .req_i(req), .mem_ack_i(ack_in),
        .gnt_o(gnt[0]), .sel_o(sel[0]), .mem_req_o(mreq[0]), .ack_o(ack[0]),
        .err_o(err[0]), .err_id_o(err_id[0]), .busy_o(busy[0])
    );

    mem_port_arbiter5 #(.PRIO0_FIXED(1), .TIMEOUT_CYCLES(TMO), .CNT_W(4)) dut_fp (
        .clk(clk), .rst(rst), .req_i(req), .mem_ack_i(ack_in),
        .gnt_o(gnt[1]), .sel_o(sel[1]), .mem_req_o(mreq[1]), .ack_o(ack[1]),
        .err_o(err[1]), .err_id_o(err_id[1]), .busy_o(busy[1])
    );

    task automatic chk(input string name, input int j, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s dut%0d: got %0d expected %0d (t=%0t)", name, j, act, expv, $time);
        end
    endtask

    // Reference arbitration rule: fixed 0 first if enabled, else first requester at ptr, ptr+1, ... mod 5.
    function automatic int pick(input logic [4:0] r, input int ptr, input bit prio0);
        if (prio0 && r[0]) return 0;
        for (int k = 0; k < 5; k++) begin
            int i;
            i = (ptr + k) % 5;
            if (prio0 && i == 0) continue;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        for (int j = 0; j < 2; j++) begin
            if (rst) begin
                prev_gnt[j] = 5'd0;
            end else begin
                if (gnt[j] != 5'd0) begin
                    if (prev_gnt[j] == 5'd0) begin
                        if (rd_idx[j] < exp_q.size()) begin
                            cur_w[j] = (j == 0) ? exp_q[rd_idx[j]].w0 : exp_q[rd_idx[j]].w1;
                            rd_idx[j]++;
                        end else begin
                            chk("spurious_grant", j, gnt[j], 0);
                            cur_w[j] = -1;
                        end
                    end
                    chk("gnt", j, gnt[j], 32'd1 << cur_w[j]);
                    chk("sel", j, sel[j], cur_w[j]);
                    chk("mem_req", j, mreq[j], 1);
                    chk("busy", j, busy[j], 1);
                    chk("ack", j, ack[j], ack_in ? (32'd1 << cur_w[j]) : 0);
                    if (ack[j] != 5'd0) acks_seen[j]++;
                end else begin
                    chk("idle_sel", j, sel[j], 5);
                    chk("idle_mem_req", j, mreq[j], 0);
                    chk("idle_busy", j, busy[j], 0);
                    chk("idle_ack", j, ack[j], 0);
                end
                if (err[j]) begin
                    errs_seen[j]++;
                    chk("err_id", j, err_id[j], cur_w[j]);
                end else begin
                    chk("err_id_zero", j, err_id[j], 0);
                end
                prev_gnt[j] = gnt[j];
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        req = 5'd0;
        ack_in = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        ptr_m[0] = 0;
        ptr_m[1] = 0;
    endtask

    // One grant: r presented in an IDLE cycle, busy_r during BUSY, ack in BUSY cycle ack_k (>= TMO: none).
    task automatic txn(input logic [4:0] r, input logic [4:0] busy_r, input int ack_k);
        rec_t rc;
        req = r;
        ack_in = 1'($urandom_range(0, 1));
        rc.w0 = pick(r, ptr_m[0], 1'b0);
        rc.w1 = pick(r, ptr_m[1], 1'b1);
        exp_q.push_back(rc);
        ptr_m[0] = (rc.w0 + 1) % 5;
        ptr_m[1] = (rc.w1 + 1) % 5;
        @(posedge clk);
        #1;
        for (int k = 0; k < TMO; k++) begin
            req = busy_r;
            ack_in = (k == ack_k);
            if (k == ack_k) exp_acks++;
            @(posedge clk);
            #1;
            if (k == ack_k) break;
        end
        req = 5'd0;
        ack_in = 1'b0;
        if (ack_k >= TMO) exp_errs++;
    endtask

    initial begin
        rst = 1'b1;
        req = 5'd0;
        ack_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        for (int j = 0; j < 2; j++) begin
            chk("rst_gnt", j, gnt[j], 0);
            chk("rst_sel", j, sel[j], 5);
            chk("rst_mem_req", j, mreq[j], 0);
            chk("rst_err", j, err[j], 0);
        end

        txn(5'b00100, 5'b00000, 2);

        do_reset();
        repeat (6) txn(5'b11111, 5'b11111, 2);

        do_reset();
        txn(5'b11110, 5'b11111, 1);
        txn(5'b11111, 5'b11111, 1);
        txn(5'b11101, 5'b11101, 1);

        txn(5'b01000, 5'b01000, TMO);
        txn(5'b01000, 5'b01000, TMO - 1);

        // Abandon a grant owned by requester 4 with a reset in its second BUSY cycle.
        req = 5'b10000;
        begin
            rec_t rc;
            rc.w0 = 4;
            rc.w1 = 4;
            exp_q.push_back(rc);
        end
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        do_reset();
        txn(5'b10001, 5'b10001, 0);

        repeat (200) begin
            if ($urandom_range(0, 5) == 0) begin
                req = 5'd0;
                ack_in = 1'($urandom_range(0, 1));
                @(posedge clk);
                #1;
                ack_in = 1'b0;
            end else begin
                txn(5'($urandom_range(1, 31)), 5'($urandom_range(0, 31)), $urandom_range(0, TMO + 1));
            end
        end

        req = 5'd0;
        ack_in = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int j = 0; j < 2; j++) begin
            chk("grants_consumed", j, rd_idx[j], exp_q.size());
            chk("ack_count", j, acks_seen[j], exp_acks);
            chk("err_count", j, errs_seen[j], exp_errs);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
